// File: rtl/axis_dwc_pkg.sv
// Shared types and helpers for the AXI-Stream width downsizer.
// Subword helpers work on a per-position non-null mask, up to 16 subwords.
package axis_dwc_pkg;

    typedef enum logic {ST_EMPTY, ST_DRAIN} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Emission order index -> subword position in the wide word.
    function automatic int pos_of(input int e, input int ratio,
                                  input bit msw_first);
        return msw_first ? (ratio - 1 - e) : e;
    endfunction

    // Last emission index whose subword has any keep bit; 0 if none.
    function automatic int find_last_nz(input logic [15:0] nz,
                                        input int ratio,
                                        input bit msw_first);
        int r;
        r = 0;
        for (int e = 0; e < 16; e++) begin
            if (e < ratio) begin
                if (nz[4'(pos_of(e, ratio, msw_first))]) r = e;
            end
        end
        return r;
    endfunction

    // First emission index after 'from' with a non-null subword;
    // returns ratio when there is none.
    function automatic int find_next_nz(input logic [15:0] nz,
                                        input int from,
                                        input int ratio,
                                        input bit msw_first);
        int r;
        r = ratio;
        for (int e = 15; e >= 0; e--) begin
            if (e < ratio && e > from) begin
                if (nz[4'(pos_of(e, ratio, msw_first))]) r = e;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_dwc_down.sv
// AXI-Stream width downsizer: each wide beat becomes up to RATIO narrow
// beats. Trailing null subwords of a tlast beat are trimmed.
// Build option: AXIS_DWC_SKIP_NULL_EN skips null subwords in every beat.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_axis_*          wide input stream (tvalid/tdata/tkeep/tlast/tready)
//   m_axis_*          narrow output stream (tvalid/tdata/tkeep/tlast/tready)
//   busy              holding register occupied
module axis_dwc_down
    import axis_dwc_pkg::*;
#(
    parameter int IN_BYTES  = 8,
    parameter int RATIO     = 2,
    parameter int MSW_FIRST = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_axis_tvalid,
    input  logic [IN_BYTES*8-1:0]           s_axis_tdata,
    input  logic [IN_BYTES-1:0]             s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic                            m_axis_tvalid,
    output logic [(IN_BYTES/RATIO)*8-1:0]   m_axis_tdata,
    output logic [IN_BYTES/RATIO-1:0]       m_axis_tkeep,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic                            busy
);

    localparam int OUT_BYTES = IN_BYTES / RATIO;
    localparam int OW        = OUT_BYTES * 8;
    localparam int IW        = clog2(RATIO);
    localparam bit MSW       = (MSW_FIRST != 0);

    state_t                state_q, state_n;
    logic [IN_BYTES*8-1:0] data_q;
    logic [IN_BYTES-1:0]   keep_q;
    logic                  last_q;
    logic [IW-1:0]         idx_q, idx_n, lidx_q;
    logic [IW-1:0]         s_lidx, s_first, idx_step, m_pos;
    logic [15:0]           s_nz;
    logic                  hv, at_last, m_hs, s_hs, cap, skip;

    always_comb begin
        s_nz = '0;
        for (int p = 0; p < RATIO; p++)
            s_nz[p] = |s_axis_tkeep[p*OUT_BYTES +: OUT_BYTES];
    end

`ifdef AXIS_DWC_SKIP_NULL_EN
    logic [15:0] h_nz;

    always_comb begin
        h_nz = '0;
        for (int p = 0; p < RATIO; p++)
            h_nz[p] = |keep_q[p*OUT_BYTES +: OUT_BYTES];
    end
`endif

    // Capture-time plan for the incoming beat and the step rule.
    always_comb begin
        s_lidx  = IW'(find_last_nz(s_nz, RATIO, MSW));
        s_first = '0;
        skip    = 1'b0;
`ifdef AXIS_DWC_SKIP_NULL_EN
        if (|s_nz)
            s_first = IW'(find_next_nz(s_nz, -1, RATIO, MSW));
        skip     = !s_axis_tlast && !(|s_nz);
        idx_step = IW'(find_next_nz(h_nz, int'(idx_q), RATIO, MSW));
`else
        if (!s_axis_tlast)
            s_lidx = IW'(RATIO - 1);
        idx_step = idx_q + IW'(1);
`endif
    end

    assign hv            = (state_q == ST_DRAIN);
    assign at_last       = (idx_q == lidx_q);
    assign m_hs          = hv && m_axis_tready;
    assign s_axis_tready = !hv || (m_axis_tready && at_last);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    // Fully null non-last beats are swallowed when skipping is enabled.
    assign cap           = s_hs && !skip;

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (cap) begin
                    state_n = ST_DRAIN;
                    idx_n   = s_first;
                end
            end
            ST_DRAIN: begin
                if (m_hs) begin
                    if (!at_last)
                        idx_n = idx_step;
                    else if (cap)
                        idx_n = s_first;
                    else
                        state_n = ST_EMPTY;
                end
            end
            default: state_n = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            lidx_q <= '0;
        end else if (cap) begin
            data_q <= s_axis_tdata;
            keep_q <= s_axis_tkeep;
            last_q <= s_axis_tlast;
            lidx_q <= s_lidx;
        end
    end

    assign m_pos         = MSW ? (IW'(RATIO - 1) - idx_q) : idx_q;
    assign m_axis_tvalid = hv;
    assign m_axis_tdata  = data_q[m_pos*OW +: OW];
    assign m_axis_tkeep  = keep_q[m_pos*OUT_BYTES +: OUT_BYTES];
    assign m_axis_tlast  = last_q && at_last;
    assign busy          = hv;

endmodule

// File: tb/tb_axis_dwc_down.sv
// Randomised and directed bench for axis_dwc_down with a queue model.
// Model expands each accepted wide beat into its narrow beats directly.
module tb_axis_dwc_down;

    localparam int IN_BYTES  = 8;
    localparam int RATIO     = 2;
    localparam int MSW_FIRST = 1;
    localparam int OB        = IN_BYTES / RATIO;
    localparam int IWD       = IN_BYTES * 8;
    localparam int OW        = OB * 8;

    typedef struct packed {
        logic [OW-1:0] d;
        logic [OB-1:0] k;
        logic          l;
    } nb_t;

    logic           clk, rst;
    logic           s_tvalid, s_tlast, s_tready;
    logic [IWD-1:0] s_tdata;
    logic [IN_BYTES-1:0] s_tkeep;
    logic           m_tvalid, m_tlast, m_tready, busy;
    logic [OW-1:0]  m_tdata;
    logic [OB-1:0]  m_tkeep;

    axis_dwc_down #(
        .IN_BYTES (IN_BYTES),
        .RATIO    (RATIO),
        .MSW_FIRST(MSW_FIRST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tlast (m_tlast),
        .m_axis_tready(m_tready),
        .busy         (busy)
    );

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  rmode   = 0;
    nb_t exp_q[$];
    nb_t got_q[$];
    int  got_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    // Narrow beats a wide beat must produce, from the subword rules.
    function automatic void expand(input logic [IWD-1:0] d,
                                   input logic [IN_BYTES-1:0] k,
                                   input logic l);
        int  last_e, fin, p;
        bit  nz, emit;
        nb_t b;
        last_e = -1;
        for (int e = 0; e < RATIO; e++) begin
            p = MSW_FIRST ? RATIO - 1 - e : e;
            if (|k[p*OB +: OB]) last_e = e;
        end
        fin = (last_e < 0) ? 0 : last_e;
        for (int e = 0; e < RATIO; e++) begin
            p  = MSW_FIRST ? RATIO - 1 - e : e;
            nz = |k[p*OB +: OB];
`ifdef AXIS_DWC_SKIP_NULL_EN
            emit = nz || (l && last_e < 0 && e == 0);
`else
            emit = !l || e <= fin;
`endif
            if (emit) begin
                b.d = d[p*OW +: OW];
                b.k = k[p*OB +: OB];
                b.l = l && (e == fin);
                exp_q.push_back(b);
            end
        end
    endfunction

    logic pv = 1'b0, pr = 1'b0, prst = 1'b0;
    bit   armed = 1'b0;
    nb_t  pb;

    always @(negedge clk) begin
        nb_t cur;
        bit  rdy;
        cur = '{d: m_tdata, k: m_tkeep, l: m_tlast};
        if (armed) begin
            rdy = (exp_q.size() == 0) ||
                  (exp_q.size() == 1 && m_tready);
            chk("m_tvalid", 64'(m_tvalid), 64'(exp_q.size() != 0));
            chk("busy", 64'(busy), 64'(exp_q.size() != 0));
            chk("s_tready", 64'(s_tready), 64'(rdy));
            if (prst)
                chk("reset_out", 64'(cur), 64'(0));
            if (!prst && pv && !pr) begin
                chk("hold_valid", 64'(m_tvalid), 64'(1));
                chk("hold_beat", 64'(cur), 64'(pb));
            end
            if (!rst && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(cur), 64'(0));
                end else begin
                    chk("beat", 64'(cur), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                    got_q.push_back(cur);
                    got_cyc.push_back(cyc);
                end
            end
        end
        if (rst) begin
            exp_q.delete();
            armed = 1'b1;
        end else if (armed && s_tvalid && s_tready) begin
            expand(s_tdata, s_tkeep, s_tlast);
        end
        pv   = m_tvalid;
        pr   = m_tready;
        pb   = cur;
        prst = rst;
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       m_tready = ~m_tready;
                2:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [IWD-1:0] d,
                        input logic [IN_BYTES-1:0] k, input logic l);
        bit hs;
        int t;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        t = 0;
        forever begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            if (hs) break;
            t++;
            if (t > 100) begin
                chk("send_timeout", 64'(t), 64'(0));
                break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_tvalid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300)
            chk("drain_timeout", 64'(t), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_got(input string nm, input int i,
                           input logic [OW-1:0] d, input logic [OB-1:0] k,
                           input logic l);
        nb_t e, a;
        e = '{d: d, k: k, l: l};
        a = (got_q.size() > i) ? got_q[i] : '0;
        chk(nm, 64'(a), 64'(e));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        got_q.delete();
        send(64'h1122334455667788, 8'hFF, 1'b1);
        wait_idle();
        chk("order_n", 64'(got_q.size()), 64'(2));
        chk_got("order_0", 0, 32'h11223344, 4'hF, 1'b0);
        chk_got("order_1", 1, 32'h55667788, 4'hF, 1'b1);

        got_q.delete();
        send(64'h1122334455667788, 8'hF0, 1'b1);
        chk("trim_ready", 64'(s_tready), 64'(1));
        wait_idle();
        chk("trim_n", 64'(got_q.size()), 64'(1));
        chk_got("trim_0", 0, 32'h11223344, 4'hF, 1'b1);

        got_q.delete();
        send(64'h1122334455667788, 8'h00, 1'b1);
        wait_idle();
        chk("null_n", 64'(got_q.size()), 64'(1));
        chk_got("null_0", 0, 32'h11223344, 4'h0, 1'b1);

        got_q.delete();
        send(64'h1122334455667788, 8'h0F, 1'b0);
        wait_idle();
`ifdef AXIS_DWC_SKIP_NULL_EN
        chk("lo_n", 64'(got_q.size()), 64'(1));
        chk_got("lo_0", 0, 32'h55667788, 4'hF, 1'b0);
`else
        chk("lo_n", 64'(got_q.size()), 64'(2));
        chk_got("lo_0", 0, 32'h11223344, 4'h0, 1'b0);
        chk_got("lo_1", 1, 32'h55667788, 4'hF, 1'b0);
`endif

        got_q.delete();
        got_cyc.delete();
        for (int i = 0; i < 4; i++)
            send({$urandom, $urandom}, 8'hFF, 1'(i == 3));
        wait_idle();
        chk("tput_n", 64'(got_q.size()), 64'(8));
        if (got_cyc.size() == 8)
            chk("tput_gap", 64'(got_cyc[7] - got_cyc[0]), 64'(7));

        got_q.delete();
        rmode = 1;
        for (int i = 0; i < 4; i++)
            send({$urandom, $urandom}, 8'hFF, 1'(i == 3));
        wait_idle();
        chk("bp_n", 64'(got_q.size()), 64'(8));
        rmode = 0;

        rmode = 2;
        for (int i = 0; i < 300; i++) begin
            logic [IN_BYTES-1:0] k;
            case ($urandom_range(0, 4))
                0:       k = 8'hFF;
                1:       k = 8'h00;
                2:       k = 8'hF0;
                3:       k = 8'h0F;
                default: k = 8'($urandom);
            endcase
            send({$urandom, $urandom}, k, 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        rmode = 0;

        got_q.delete();
        send(64'hAABBCCDDEEFF0011, 8'hFF, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 64'(m_tvalid), 64'(0));
        chk("rst_n", 64'(got_q.size()), 64'(1));
        chk_got("rst_0", 0, 32'hAABBCCDD, 4'hF, 1'b0);
        send(64'h0102030405060708, 8'hFF, 1'b1);
        wait_idle();
        chk("post_n", 64'(got_q.size()), 64'(3));
        chk_got("post_1", 1, 32'h01020304, 4'hF, 1'b0);
        chk_got("post_2", 2, 32'h05060708, 4'hF, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
